rgb_compare_hold: RTL and testbench
===================================

# rgb_compare_hold

Parametrised sequential magnitude comparator driving an RGB indicator: it compares two WIDTH-bit operands on a sample strobe and displays less-than, equal or greater-than on the red, green and blue outputs. A minimum-hold timer suppresses display flicker, and a PWM stage dims the LED drive. It sits between the board switch/operand logic and the RGB LED pins, and supersedes the fixed 2-bit combinational comparator.

## Interface
- WIDTH, 4, operand width in bits (≥1)
- PWM_BITS, 8, PWM counter and duty width (≥2)
- HOLD_CYCLES, 1000, minimum cycles a displayed result persists before it may change (≥1)
---
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- sample  in  1  capture strobe; a/b are registered when high
- clear  in  1  force display to OFF, bypassing hold
- duty  in  PWM_BITS  brightness; 0 = dark, all-ones = full on
- red  out  1  lit when displayed result is a<b
- green  out  1  lit when displayed result is a==b
- blue  out  1  lit when displayed result is a>b
- disp  out  2  displayed state code: OFF=0, LT=1, EQ=2, GT=3

## Operation
- Reset: red/green/blue=0, disp=OFF, operand/result/pending registers 0, hold counter 0, PWM counter 0, pending-valid=0.
- Stage 1: sample=1 registers a,b into a_q,b_q and sets cmp_vld; otherwise cmp_vld=0.
- Stage 2: when cmp_vld, unsigned compare of a_q,b_q produces LT/EQ/GT into res_q with res_vld.
- Display FSM, states OFF, LT, EQ, GT:
  - OFF exits only on res_vld; goes directly to res_q regardless of the hold counter.
  - In LT/EQ/GT: res_vld with res_q == disp → no change, no hold reload, pending cleared.
  - res_vld with res_q ≠ disp, hold counter == 0 → disp<=res_q, hold counter loads HOLD_CYCLES-1.
  - res_vld with res_q ≠ disp, hold counter ≠ 0 → res_q stored as pending (latest wins, overwrites older pending).
  - Hold counter reaches 0 with pending-valid → disp<=pending, reload hold, clear pending. A res_vld in the same cycle takes priority over the pending value.
  - clear=1 → disp=OFF, hold counter=0, pending cleared, in-flight cmp_vld/res_vld killed; clear beats all other events.
- Hold counter decrements by 1 each cycle while nonzero; saturates at 0.
- PWM: free-running PWM_BITS counter, wraps to 0. Channel enable = (cnt < duty) or (duty == all-ones).
- Output stage: exactly one of red/green/blue selected by disp (none for OFF), ANDed with PWM enable, registered.

## Timing
- Latency sample edge → disp update: 2 cycles (edges k+1 compare, k+2 disp) when not held.
- disp → red/green/blue: 1 further cycle (registered outputs); total 3 cycles at full duty.
- Back-to-back samples accepted every cycle; fully pipelined.
- Reset asynchronous: outputs reach 0 without a clock edge; deassertion is synchronised externally.
- PWM period 2^PWM_BITS cycles; duty=d gives d high cycles per period (d < all-ones).

## Configuration
- RGB_PWM_EN defined: PWM counter and duty gating implemented as above.
- RGB_PWM_EN undefined: no PWM counter; duty port present but ignored; selected colour is steady high while disp selects it.

## Structure
- Package rgb_cmp_pkg: enum disp_e {DISP_OFF=0, DISP_LT=1, DISP_EQ=2, DISP_GT=3} and function cmp_result(a,b) returning disp_e.
- Sub-module rgb_pwm_gen (PWM counter + enable compare, parameter PWM_BITS), instantiated only under RGB_PWM_EN.

## Test plan
All with WIDTH=4, PWM_BITS=4, HOLD_CYCLES=8, duty=4'hF unless stated.
- Reset mid-run with blue lit → red=green=blue=0, disp=0 immediately, before next clk edge.
- Exhaustive sweep a,b ∈ 0..15, clear pulsed between vectors → correct colour 3 cycles after each sample (e.g. a=3,b=9 → red; a=7,b=7 → green; a=12,b=5 → blue).
- a=2,b=2 then next cycle a=9,b=1 → green shown; blue held off 8 cycles then appears; disp steps 2→3.
- During hold from EQ, sample LT then GT → only GT displayed at hold expiry; LT never appears.
- clear=1 coincident with sample → disp=0, outputs dark, that sample discarded.
- RGB_PWM_EN defined, duty=4, disp=EQ → green high exactly 4 of every 16 cycles; duty=0 → never high; undefined → green steady high.

Source files
------------

// File: rtl/rgb_cmp_pkg.sv
// -----------------------------------------------------------------------------
// rgb_cmp_pkg
//
// Shared types and helpers for the RGB magnitude-compare indicator.
//   disp_e      : displayed state code (OFF/LT/EQ/GT), also the encoding of
//                 the 2-bit disp output and of the display FSM state.
//   cmp_result  : unsigned magnitude compare of two operands, returning the
//                 disp_e code that should be shown for them.
//
// Operands are passed zero-extended to CMP_W bits so a single function serves
// every operand width up to CMP_W.
// -----------------------------------------------------------------------------
package rgb_cmp_pkg;

    // Widest operand the shared compare helper accepts.
    localparam int CMP_W = 64;

    typedef enum logic [1:0] {
        DISP_OFF = 2'd0,
        DISP_LT  = 2'd1,
        DISP_EQ  = 2'd2,
        DISP_GT  = 2'd3
    } disp_e;

    // Unsigned compare; callers zero-extend their operands to CMP_W bits.
    function automatic disp_e cmp_result(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b
    );
        if (a < b) begin
            return DISP_LT;
        end else if (a == b) begin
            return DISP_EQ;
        end else begin
            return DISP_GT;
        end
    endfunction

endpackage : rgb_cmp_pkg

// File: rtl/rgb_pwm_gen.sv
// -----------------------------------------------------------------------------
// rgb_pwm_gen
//
// Free-running PWM counter and duty compare used to dim the RGB LED drive.
// The counter wraps every 2^PWM_BITS cycles; en is high for `duty` cycles of
// each period, and constantly high when duty is all-ones so that "full on"
// really is full on (a plain cnt < duty would leave one dark cycle).
//
// Parameters:
//   PWM_BITS : counter / duty width (>= 2)
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (counter -> 0)
//   duty  in   brightness, 0 = dark, all-ones = full on
//   en    out  channel enable for the current cycle (combinational from cnt)
// -----------------------------------------------------------------------------
module rgb_pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                en
);

    logic [PWM_BITS-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PWM_BITS'(1);
        end
    end

    assign en = (cnt < duty) || (&duty);

endmodule : rgb_pwm_gen

// File: rtl/rgb_compare_hold.sv
// -----------------------------------------------------------------------------
// rgb_compare_hold
//
// Sequential magnitude comparator driving an RGB indicator. Operands are
// captured on a sample strobe, compared one cycle later, and the result is
// shown on red (a<b), green (a==b) or blue (a>b). A minimum-hold timer keeps a
// displayed result for at least HOLD_CYCLES cycles; results arriving during
// the hold are parked as a single pending value (latest wins) and shown when
// the hold expires. A PWM stage dims the LED drive.
//
// Build option:
//   RGB_PWM_EN  defined   : PWM counter + duty gating of the colour outputs.
//               undefined : no PWM counter, duty is ignored, the selected
//                           colour is steady high.
//
// Parameters:
//   WIDTH       : operand width in bits (1..64)
//   PWM_BITS    : PWM counter and duty width (>= 2)
//   HOLD_CYCLES : minimum cycles a displayed result persists (>= 1)
// Ports:
//   clk    in   system clock, all state on rising edge
//   rst    in   asynchronous active-high reset
//   a, b   in   unsigned operands, registered when sample is high
//   sample in   capture strobe (no backpressure: accepted every cycle)
//   clear  in   force display OFF, bypassing hold, killing in-flight samples
//   duty   in   PWM brightness
//   red    out  displayed result is a<b   (registered, PWM gated)
//   green  out  displayed result is a==b  (registered, PWM gated)
//   blue   out  displayed result is a>b   (registered, PWM gated)
//   disp   out  displayed state code OFF=0 LT=1 EQ=2 GT=3; this is the
//               display FSM state itself, exposed for observation
//
// Timing: sample at edge k -> compare at k+1 -> disp at k+2 (when not held)
// -> colour outputs at k+3.
// -----------------------------------------------------------------------------
module rgb_compare_hold
    import rgb_cmp_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int PWM_BITS    = 8,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                sample,
    input  logic                clear,
    input  logic [PWM_BITS-1:0] duty,
    output logic                red,
    output logic                green,
    output logic                blue,
    output logic [1:0]          disp
);

    // Hold counter only has to reach HOLD_CYCLES-1; keep it at least 1 bit.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    // ---------------------------------------------------------------
    // Stage 1: operand capture
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cmp_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            cmp_vld <= 1'b0;
        end else begin
            // A sample coincident with clear is discarded.
            cmp_vld <= sample && !clear;
            if (sample) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: compare
    // ---------------------------------------------------------------
    disp_e res_q;
    logic  res_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= DISP_OFF;
            res_vld <= 1'b0;
        end else begin
            // clear kills the sample sitting in stage 1.
            res_vld <= cmp_vld && !clear;
            if (cmp_vld) begin
                res_q <= cmp_result(CMP_W'(a_q), CMP_W'(b_q));
            end
        end
    end

    // ---------------------------------------------------------------
    // Display FSM with minimum-hold timer and one-deep pending slot
    // ---------------------------------------------------------------
    disp_e             disp_q;
    disp_e             pend_q;
    logic              pend_vld;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q   <= DISP_OFF;
            pend_q   <= DISP_OFF;
            pend_vld <= 1'b0;
            hold_cnt <= '0;
        end else if (clear) begin
            // clear wins over every other event, including a res_vld
            // arriving this cycle (that result is dropped).
            disp_q   <= DISP_OFF;
            pend_q   <= DISP_OFF;
            pend_vld <= 1'b0;
            hold_cnt <= '0;
        end else begin
            // Saturating down-count; overridden below on a reload.
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end

            case (disp_q)
                DISP_OFF: begin
                    // Leaving OFF ignores the hold timer but still starts
                    // a hold on the first displayed result.
                    if (res_vld) begin
                        disp_q   <= res_q;
                        hold_cnt <= HOLD_RELOAD;
                        pend_vld <= 1'b0;
                    end
                end

                default: begin
                    if (res_vld) begin
                        // A fresh result always takes priority over the
                        // pending one.
                        if (res_q == disp_q) begin
                            // Same answer as shown: drop any stale pending
                            // change, keep the running hold.
                            pend_vld <= 1'b0;
                        end else if (hold_cnt == '0) begin
                            disp_q   <= res_q;
                            hold_cnt <= HOLD_RELOAD;
                            pend_vld <= 1'b0;
                        end else begin
                            // Held: remember only the most recent result.
                            pend_q   <= res_q;
                            pend_vld <= 1'b1;
                        end
                    end else if (pend_vld && (hold_cnt == '0)) begin
                        disp_q   <= pend_q;
                        hold_cnt <= HOLD_RELOAD;
                        pend_vld <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign disp = disp_q;

    // ---------------------------------------------------------------
    // PWM enable
    // ---------------------------------------------------------------
    logic pwm_en;

`ifdef RGB_PWM_EN
    rgb_pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .duty (duty),
        .en   (pwm_en)
    );
`else
    // Without dimming the selected colour is steady; duty is kept as a port
    // for pin compatibility and deliberately folded into an unused net.
    logic unused_duty;
    assign unused_duty = ^duty;
    assign pwm_en      = 1'b1;
`endif

    // ---------------------------------------------------------------
    // Output stage: one-hot colour select from disp, PWM gated, registered
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else begin
            red   <= (disp_q == DISP_LT) && pwm_en;
            green <= (disp_q == DISP_EQ) && pwm_en;
            blue  <= (disp_q == DISP_GT) && pwm_en;
        end
    end

endmodule : rgb_compare_hold

// File: tb/tb_rgb_compare_hold.sv
// -----------------------------------------------------------------------------
// tb_rgb_compare_hold
//
// Bench for rgb_compare_hold with WIDTH=4, PWM_BITS=4, HOLD_CYCLES=8.
// A timestamp-based reference model predicts disp and the colour outputs
// every cycle; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rgb_compare_hold;

    localparam int W    = 4;
    localparam int PB   = 4;
    localparam int HOLD = 8;

    // ---------------- clock / reset / DUT ----------------
    logic          clk;
    logic          rst;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sample;
    logic          clear;
    logic [PB-1:0] duty;
    logic          red;
    logic          green;
    logic          blue;
    logic [1:0]    disp;

    int n_chk  = 0;
    int n_pass = 0;
    bit run    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rgb_compare_hold #(
        .WIDTH       (W),
        .PWM_BITS    (PB),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .sample (sample),
        .clear  (clear),
        .duty   (duty),
        .red    (red),
        .green  (green),
        .blue   (blue),
        .disp   (disp)
    );

    // ---------------- reference model ----------------
    function automatic logic [1:0] ref_cmp(input int x, input int y);
        if (x < y) return 2'd1;
        if (x == y) return 2'd2;
        return 2'd3;
    endfunction

    function automatic bit pwm_on(input int phase, input int d);
        bit on;
        on = (phase < d) || (d == (1 << PB) - 1);
`ifndef RGB_PWM_EN
        on = 1'b1;
`endif
        return on;
    endfunction

    // {red, green, blue}
    function automatic logic [2:0] led_of(input logic [1:0] d, input bit on);
        if (!on) return 3'b000;
        case (d)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Results in flight: code and the edge at which it reaches the display.
    logic [1:0] exp_q[$];
    int         due_q[$];

    int         n;        // rising edges since reset release
    logic [1:0] dm;       // model displayed state
    int         lc;       // edge of the last display change
    bit         pv;       // pending valid
    logic [1:0] pd;       // pending code
    logic [2:0] exp_rgb;  // expected {red,green,blue} after this edge
    bit         m_got;
    bit         m_can;
    logic [1:0] m_code;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n       = 0;
            dm      = 2'd0;
            lc      = -HOLD;
            pv      = 1'b0;
            pd      = 2'd0;
            exp_rgb = 3'b000;
            exp_q.delete();
            due_q.delete();
        end else begin
            n++;
            // Outputs register the display state and PWM phase seen before this edge.
            exp_rgb = led_of(dm, pwm_on((n - 1) % (1 << PB), int'(duty)));
            if (clear) begin
                exp_q.delete();
                due_q.delete();
                dm = 2'd0;
                pv = 1'b0;
                lc = n - HOLD;
            end else begin
                m_got = 1'b0;
                if (due_q.size() > 0 && due_q[0] == n) begin
                    m_code = exp_q.pop_front();
                    void'(due_q.pop_front());
                    m_got  = 1'b1;
                end
                if (sample) begin
                    exp_q.push_back(ref_cmp(int'(a), int'(b)));
                    due_q.push_back(n + 2);
                end
                // A change is allowed once HOLD edges have passed since the last one.
                m_can = (n - lc) >= HOLD;
                if (dm == 2'd0) begin
                    if (m_got) begin
                        dm = m_code;
                        lc = n;
                    end
                end else if (m_got) begin
                    if (m_code == dm) begin
                        pv = 1'b0;
                    end else if (m_can) begin
                        dm = m_code;
                        lc = n;
                        pv = 1'b0;
                    end else begin
                        pd = m_code;
                        pv = 1'b1;
                    end
                end else if (pv && m_can) begin
                    dm = pd;
                    lc = n;
                    pv = 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clk) begin
        if (run && !rst) begin
            n_chk++;
            if (disp === dm && {red, green, blue} === exp_rgb) begin
                n_pass++;
            end else begin
                $display("FAIL model cycle %0d: disp=%0d rgb=%b, expected disp=%0d rgb=%b",
                         n, disp, {red, green, blue}, dm, exp_rgb);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Sample one vector, then idle until its colour is on the outputs.
    task automatic show(input int x, input int y);
        a      = W'(x);
        b      = W'(y);
        sample = 1'b1;
        step();
        sample = 1'b0;
        repeat (3) step();
    endtask

    // ---------------- stimulus ----------------
    int cnt_hi;
    bit seen_lt;

    initial begin
        rst    = 1'b1;
        a      = '0;
        b      = '0;
        sample = 1'b0;
        clear  = 1'b0;
        duty   = 4'hF;
        repeat (2) @(negedge clk);
        check("reset_disp", int'(disp), 0);
        check("reset_rgb", int'({red, green, blue}), 0);
        rst = 1'b0;
        run = 1'b1;

        // Exhaustive sweep with clear between vectors.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_clear();
                show(x, y);
                check($sformatf("sweep_%0d_%0d", x, y), int'({red, green, blue}),
                      (x < y) ? 4 : ((x == y) ? 2 : 1));
            end
        end
        do_clear();
        show(3, 9);
        check("a3_b9_red", int'({red, green, blue}), 4);
        do_clear();
        show(7, 7);
        check("a7_b7_green", int'({red, green, blue}), 2);
        do_clear();
        show(12, 5);
        check("a12_b5_blue", int'({red, green, blue}), 1);

        // EQ then GT on the next cycle: GT held off for the hold time.
        do_clear();
        a = 4'd2; b = 4'd2; sample = 1'b1;
        step();                       // edge k
        a = 4'd9; b = 4'd1;
        step();                       // edge k+1
        sample = 1'b0;
        step();                       // edge k+2
        check("eq_shown_disp", int'(disp), 2);
        step();                       // edge k+3
        check("eq_green", int'(green), 1);
        repeat (6) step();            // edge k+9
        check("eq_still_held", int'(disp), 2);
        check("blue_off_in_hold", int'(blue), 0);
        step();                       // edge k+10
        check("gt_after_hold", int'(disp), 3);
        step();                       // edge k+11
        check("blue_after_hold", int'(blue), 1);

        // During an EQ hold, LT then GT arrive: only GT ever appears.
        do_clear();
        a = 4'd5; b = 4'd5; sample = 1'b1;
        step();                       // edge k
        sample = 1'b0;
        step();
        step();                       // edge k+2: EQ shown
        a = 4'd1; b = 4'd2; sample = 1'b1;
        step();                       // edge k+3
        a = 4'd8; b = 4'd3;
        step();                       // edge k+4
        sample  = 1'b0;
        seen_lt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();                   // edge k+5+i
            if (disp == 2'd1 || red) seen_lt = 1'b1;
            if (i == 4) check("pend_eq_kept", int'(disp), 2);
            if (i == 5) check("pend_gt_expiry", int'(disp), 3);
        end
        check("lt_never_shown", int'(seen_lt), 0);

        // clear coincident with sample: sample discarded, display dark.
        do_clear();
        show(1, 1);
        check("pre_clear_green", int'(green), 1);
        clear = 1'b1; sample = 1'b1; a = 4'd0; b = 4'd5;
        step();
        clear = 1'b0; sample = 1'b0;
        check("clear_disp", int'(disp), 0);
        repeat (3) step();
        check("clear_disp_late", int'(disp), 0);
        check("clear_rgb_dark", int'({red, green, blue}), 0);

        // PWM duty behaviour on green.
        do_clear();
        show(7, 7);
        duty   = 4'd4;
        cnt_hi = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            cnt_hi += int'(green);
        end
`ifdef RGB_PWM_EN
        check("pwm_duty4", cnt_hi, 4);
`else
        check("pwm_duty4_steady", cnt_hi, 16);
`endif
        duty   = 4'd0;
        cnt_hi = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            cnt_hi += int'(green);
        end
`ifdef RGB_PWM_EN
        check("pwm_duty0", cnt_hi, 0);
`else
        check("pwm_duty0_steady", cnt_hi, 16);
`endif
        duty = 4'hF;

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            a      = W'($urandom_range(0, 15));
            b      = ($urandom_range(0, 4) == 0) ? a : W'($urandom_range(0, 15));
            sample = ($urandom_range(0, 3) == 0);
            clear  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0:       duty = 4'd0;
                    1:       duty = 4'd4;
                    2:       duty = 4'd9;
                    default: duty = 4'hF;
                endcase
            end
            step();
        end
        sample = 1'b0;
        clear  = 1'b0;
        duty   = 4'hF;

        // Asynchronous reset mid-run with blue lit.
        do_clear();
        show(12, 5);
        check("pre_reset_blue", int'(blue), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_rgb", int'({red, green, blue}), 0);
        check("async_reset_disp", int'(disp), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        show(3, 9);
        check("post_reset_red", int'({red, green, blue}), 4);

        run = 1'b0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_rgb_compare_hold
